// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// The optional edge pulse outputs are enabled by DEBOUNCER_EDGE_PULSE_EN.
package debouncer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_TIME = 1000;
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

  function automatic int unsigned cnt_width(
    input int unsigned t
  );
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/debouncer_sync.sv
// Multi-flop synchroniser for one asynchronous level input.
// Synchronous active-high reset clears every stage to 0.
module debouncer_sync
  import debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Single-channel button debouncer: synchroniser, hold counter, registered level.
// Define DEBOUNCER_EDGE_PULSE_EN to add press_pulse / release_pulse outputs.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic debounced_out
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic press_pulse,
  output logic release_pulse
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_TIME);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TIME - 1);

  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;
  logic             agree;
  logic             done;

  debouncer_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(button_in),
    .sync_out(sync_q)
  );

  assign agree = (sync_q == out_q);
  assign done  = !agree && (cnt_q == CNT_MAX);

  // Any agreeing sample throws away a partial count.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    unique case (1'b1)
      agree: begin
        cnt_d = '0;
      end
      done: begin
        out_d = sync_q;
        cnt_d = '0;
      end
      default: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign debounced_out = out_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic dly_q;
  logic dly_d;
  logic press_q;
  logic press_d;
  logic rel_q;
  logic rel_d;

  // Reset clears dly_q with out_q, so a reset never looks like a release.
  always_comb begin
    dly_d   = out_q;
    press_d = out_q & ~dly_q;
    rel_d   = ~out_q & dly_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with an edge-time scoreboard.
// Edge pulse checks are active when DEBOUNCER_EDGE_PULSE_EN is defined.
module tb_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic button_in;
  logic debounced_out;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic press_pulse;
  logic release_pulse;
`endif

  always #10 clk = ~clk;

  debouncer #(
    .DEBOUNCE_TIME(1000),
    .SYNC_STAGES  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .debounced_out(debounced_out)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
`endif
  );

  typedef struct {
    int   at;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_out = 1'b0;
  int   n_press = 0;
  int   n_rel = 0;
  int   press_at = -1;
  int   rel_at = -1;
  int   t0;
  int   t1;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d cyc=%0d", tag, got, want, cyc);
    end
  endtask

  task automatic expect_edge(input int at, input logic val);
    exp_t e;
    e.at  = at;
    e.val = val;
    sb.push_back(e);
  endtask

  // One clock; sample on the falling edge and score any output edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (debounced_out !== prev_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_edge", cyc, -1);
      end else begin
        e = sb.pop_front();
        chk("edge_cycle", cyc, e.at);
        chk("edge_value", int'(debounced_out), int'(e.val));
      end
      prev_out = debounced_out;
    end
    if (sb.size() != 0 && cyc > sb[0].at) begin
      chk("edge_missing", cyc, sb[0].at);
      void'(sb.pop_front());
    end
`ifdef DEBOUNCER_EDGE_PULSE_EN
    if (press_pulse === 1'b1) begin
      n_press++;
      press_at = cyc;
    end
    if (release_pulse === 1'b1) begin
      n_rel++;
      rel_at = cyc;
    end
`endif
  endtask

  task automatic waitn(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset     = 1'b1;
    button_in = 1'b0;
    waitn(5);
    reset = 1'b0;
    chk("reset_out", int'(debounced_out), 0);
    chk("reset_cnt", int'(dut.cnt_q), 0);
    waitn(2000);
    chk("idle_out", int'(debounced_out), 0);

    repeat (5) begin
      button_in = 1'b1;
      tick();
      button_in = 1'b0;
      tick();
    end
    waitn(5);
    chk("bounce_out", int'(debounced_out), 0);
    chk("bounce_cnt", int'(dut.cnt_q), 0);

    button_in = 1'b1;
    t0 = cyc;
    expect_edge(t0 + 1002, 1'b1);
    waitn(1001);
    chk("press_not_early", int'(debounced_out), 0);
    tick();
    chk("press_out", int'(debounced_out), 1);
    waitn(2000);

    button_in = 1'b0;
    t1 = cyc;
    waitn(999);
    button_in = 1'b1;
    waitn(2);
    chk("glitch_cnt_max", int'(dut.cnt_q), 999);
    chk("glitch_hold", int'(debounced_out), 1);
    tick();
    chk("glitch_cnt_clr", int'(dut.cnt_q), 0);
    waitn(1000);
    chk("glitch_out", int'(debounced_out), 1);

    button_in = 1'b0;
    t1 = cyc;
    expect_edge(t1 + 1002, 1'b0);
    waitn(1001);
    chk("release_not_early", int'(debounced_out), 1);
    waitn(100);
    chk("release_out", int'(debounced_out), 0);

`ifdef DEBOUNCER_EDGE_PULSE_EN
    chk("press_pulse_cnt", n_press, 1);
    chk("press_pulse_at", press_at, t0 + 1003);
    chk("rel_pulse_cnt", n_rel, 1);
    chk("rel_pulse_at", rel_at, t1 + 1003);
`endif

    button_in = 1'b1;
    waitn(600);
    chk("mid_cnt", int'(dut.cnt_q), 598);
    reset = 1'b1;
    tick();
    chk("mid_rst_cnt", int'(dut.cnt_q), 0);
    chk("mid_rst_sync", int'(dut.u_sync.chain_q), 0);
    reset = 1'b0;
    expect_edge(cyc + 1002, 1'b1);
    waitn(1001);
    chk("mid_not_early", int'(debounced_out), 0);
    waitn(50);
    chk("mid_rise", int'(debounced_out), 1);

    reset     = 1'b1;
    button_in = 1'b0;
    expect_edge(cyc + 1, 1'b0);
    tick();
    chk("rst_clear_out", int'(debounced_out), 0);
    reset = 1'b0;
    waitn(5);
`ifdef DEBOUNCER_EDGE_PULSE_EN
    chk("rst_no_release", n_rel, 1);
    chk("press_pulse_cnt2", n_press, 2);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
Single-channel push-button debouncer for a 50 MHz system clock.
- Synchronises an asynchronous mechanical button input into the clock domain.
- Suppresses bounce and glitches shorter than a programmable hold time.
- Produces a clean, level-stable output for downstream logic such as 7-segment display control or counters.

Parameters:
- DEBOUNCE_TIME, 1000, consecutive clock cycles the synchronised input must differ from the output before the output follows it (1000 = 20 us at 50 MHz); legal range >= 1.
- SYNC_STAGES, 2, number of synchroniser flops on button_in; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- button_in  input  1  raw asynchronous button level, active-high.
- debounced_out  output  1  debounced, registered button level.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. No asynchronous reset anywhere.
- Reset (sampled high on a clk edge):
  - all synchroniser flops <= 0
  - counter <= 0
  - debounced_out <= 0
  - reset has priority over all other activity, including mid-count; the count is discarded.
- Synchroniser: SYNC_STAGES-flop shift chain on button_in. The last stage is sync_q.
- Counter:
  - width CNT_W = $clog2(DEBOUNCE_TIME+1), unsigned.
  - Never exceeds DEBOUNCE_TIME-1; no wrap-around.
- Per clock edge, when not in reset:
  - sync_q == debounced_out: counter <= 0 (any partial count is discarded on the first agreeing sample).
  - sync_q != debounced_out and counter < DEBOUNCE_TIME-1: counter <= counter+1.
  - sync_q != debounced_out and counter == DEBOUNCE_TIME-1: debounced_out <= sync_q, counter <= 0.
- Latency: a clean input step stable from edge N changes debounced_out at edge N + SYNC_STAGES + DEBOUNCE_TIME - 1, visible after that edge. This is 1001 cycles with the defaults.
- Release is symmetric with press; the same rules apply in both directions.
- Any input pulse shorter than DEBOUNCE_TIME cycles (as seen at sync_q) never reaches debounced_out.
- DEBOUNCE_TIME = 1: the output follows sync_q with 1 cycle of delay.
- debounced_out is driven directly from a flop; there is no combinational path from button_in.

Optional Feature:
- Macro: DEBOUNCER_EDGE_PULSE_EN.
- When defined, two extra outputs are added:
  - press_pulse (1 bit): high for exactly the one cycle in which debounced_out is 0 and was 1... no: high for exactly one cycle after debounced_out transitions 0->1.
  - release_pulse (1 bit): high for exactly one cycle after debounced_out transitions 1->0.
  - Both are registered, generated from a delayed copy of debounced_out, reset to 0, and never high simultaneously.
  - A reset that clears debounced_out from 1 produces no release_pulse.
- When not defined: the ports and logic are absent, and the port list is exactly the four ports above.

Decomposition:
- Package debouncer_pkg:
  - DEFAULT_DEBOUNCE_TIME = 1000
  - DEFAULT_SYNC_STAGES = 2
  - function cnt_width(t), returning $clog2(t+1)
- Sub-module debouncer_sync: parameterised SYNC_STAGES flop chain with synchronous active-high reset to 0; instantiated once for button_in.
- Counter and compare logic stay in the top module.

Test Plan:
- Bench setup: DEBOUNCE_TIME=1000, 20 ns clk period.
- Reset: button_in=0, reset=1 for 5 cycles, then 0 -> debounced_out=0, counter=0, and debounced_out remains 0 for 2000 cycles.
- Bounce rejection: after reset, 5 repetitions of button_in 1 for 20 ns then 0 for 20 ns -> debounced_out stays 0 throughout and the counter returns to 0.
- Long press: button_in=1 held 100 us (5000 cycles) -> debounced_out rises exactly 1001 cycles after the input edge (about 20.02 us) and stays 1 until release.
- Release: button_in=0 after the long press -> debounced_out falls exactly 1001 cycles later; a 999-cycle return to 1 during this window leaves debounced_out at 1.
- Reset mid-count: button_in=1 for 600 cycles, reset pulsed for 1 cycle, button_in held at 1 -> the count restarts and debounced_out rises 1001 cycles after reset deasserts (sync stages refill).
- DEBOUNCER_EDGE_PULSE_EN builds: during the long press/release cycle, press_pulse and release_pulse are each high for exactly 1 cycle, directly after the respective debounced_out edge.
